// File: rtl/cordic_pkg.sv
// cordic_pkg: definitions shared by the CORDIC request arbiter.
//   state_t         - arbiter FSM states (2-bit encoding)
//   Q16_ONE         - 1.0 in Q16 signed fixed point
//   DEFAULT_TIMEOUT - default watchdog length in BUSY cycles
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] Q16_ONE         = 32'h0001_0000;
  localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin priority search.
// The search starts at index ptr and wraps modulo N_REQ. The first
// asserted request found is granted.
//   req       in  N_REQ  request vector
//   ptr       in  ID_W   highest-priority index
//   grant     out N_REQ  one-hot grant (zero when there are no requests)
//   grant_idx out ID_W   index of the granted requester (0 when none)
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned idx;
      // ptr + k wraps at most once, so one conditional subtract replaces a modulo.
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (grant == '0 && req[idx[ID_W-1:0]]) begin
        grant[idx[ID_W-1:0]] = 1'b1;
        grant_idx            = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin scheduler that shares one CORDIC engine
// between N_REQ requesters.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready/req_mode/req_theta
//                  per-requester request channel; req_theta is packed,
//                  with requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/rsp_ready/rsp_data/rsp_err
//                  response channel; rsp_valid is one-hot to the owner;
//                  data and err are shared; err=1 means watchdog timeout
//   cordic_start   one-cycle start pulse to the engine
//   cordic_mode/cordic_theta
//                  operands latched at acceptance
//   cordic_result/cordic_done
//                  engine return; only a rising edge of done counts
//   busy           high whenever the FSM is not idle
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_mode,
  input  logic [N_REQ*DATA_W-1:0] req_theta,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    cordic_start,
  output logic                    cordic_mode,
  output logic [DATA_W-1:0]       cordic_theta,
  input  logic [DATA_W-1:0]       cordic_result,
  input  logic                    cordic_done,
  output logic                    busy
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id;
  logic               done_d;
  logic               done_edge;
  logic [CNT_W-1:0]   cnt;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [ID_W-1:0]    ptr_next;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    grant_any = |grant;
    done_edge = cordic_done & ~done_d;
    ptr_next  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    req_ready = '0;
    // Ready is gated with rst_n so every output is low while reset is held.
    if (state == IDLE && rst_n) req_ready = grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      id           <= '0;
      done_d       <= 1'b0;
      cnt          <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      cordic_start <= 1'b0;
      cordic_mode  <= 1'b0;
      cordic_theta <= '0;
      busy         <= 1'b0;
    end else begin
      done_d       <= cordic_done;
      cordic_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            id           <= grant_idx;
            cordic_mode  <= req_mode[grant_idx];
            cordic_theta <= req_theta[grant_idx*DATA_W +: DATA_W];
            rr_ptr       <= ptr_next;
            cordic_start <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (done_edge) begin
            rsp_data  <= cordic_result;
            rsp_err   <= 1'b0;
            rsp_valid <= N_REQ'(1) << id;
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
            // The count after this increment would reach TIMEOUT-1: abort.
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= N_REQ'(1) << id;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[id]) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed self-checking bench for cordic_arbiter.
// A cycle-indexed transaction model predicts every output. A negedge
// process compares the model against the DUT. The directed sequence
// also checks literal values at key points.
module tb_cordic_arbiter;
  import cordic_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_mode = '0;
  logic [N*DW-1:0] req_theta = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '1;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic            cordic_start;
  logic            cordic_mode;
  logic [DW-1:0]   cordic_theta;
  logic [DW-1:0]   cordic_result = '0;
  logic            cordic_done = 1'b0;
  logic            busy;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  cordic_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_theta(req_theta),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cordic_start(cordic_start), .cordic_mode(cordic_mode),
    .cordic_theta(cordic_theta), .cordic_result(cordic_result),
    .cordic_done(cordic_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks one transaction with absolute cycle numbers: the
  // cycle of acceptance, the start cycle, the timeout cycle and the response.
  int          cyc = 0;
  bit          m_active = 0;
  bit          m_resp = 0;
  int          m_ptr = 0;
  int          m_id = 0;
  logic        m_mode = 1'b0;
  logic [31:0] m_theta = '0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;
  logic        m_prev_done = 1'b0;
  int          m_start_cyc = 0;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++)
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_resp = 0; m_ptr = 0; m_id = 0;
      m_mode = 1'b0; m_theta = '0; m_data = '0; m_err = 1'b0;
      m_prev_done = 1'b0;
    end else begin
      int g;
      if (!m_active) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) begin
          m_active = 1; m_id = g;
          m_mode = req_mode[g];
          m_theta = req_theta[g*DW +: DW];
          m_ptr = (g + 1) % N;
          m_start_cyc = cyc + 1;
        end
      end else if (!m_resp) begin
        if (cyc > m_start_cyc) begin
          if (cordic_done && !m_prev_done) begin
            m_resp = 1; m_data = cordic_result; m_err = 1'b0;
          end else if (cyc == m_start_cyc + TO - 1) begin
            m_resp = 1; m_data = '0; m_err = 1'b1;
          end
        end
      end else if (rsp_ready[m_id]) begin
        m_resp = 0; m_active = 0; m_data = '0; m_err = 1'b0;
      end
      m_prev_done = cordic_done;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] e_ready;
      logic [N-1:0] e_valid;
      int g;
      e_ready = '0;
      g = pick(req_valid, m_ptr);
      if (rst_n && !m_active && g >= 0) e_ready[g] = 1'b1;
      e_valid = m_resp ? (N'(1) << m_id) : '0;
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      chk("rsp_data", rsp_data, m_resp ? m_data : 32'h0);
      chk("rsp_err", 32'(rsp_err), m_resp ? 32'(m_err) : 32'h0);
      chk("cordic_start", 32'(cordic_start), 32'(m_active && !m_resp && cyc == m_start_cyc));
      chk("busy", 32'(busy), 32'(m_active));
      chk("cordic_mode", 32'(cordic_mode), 32'(m_mode));
      chk("cordic_theta", cordic_theta, m_theta);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int s_cyc;
    int n_rsp;
    bit seen;

    rst_n = 1'b0;
    tick(); tick();
    chk_en = 1;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single request, sin(30 deg).
    req_mode = 4'b0001;
    req_theta[0*DW +: DW] = 32'h001E_0000;
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    // Requester changes after acceptance must not reach the engine.
    req_valid = '0;
    req_mode = '0;
    req_theta[0*DW +: DW] = 32'h0055_0000;
    #1;
    chk("t1_start", 32'(cordic_start), 32'h1);
    chk("t1_theta", cordic_theta, 32'h001E_0000);
    chk("t1_mode", 32'(cordic_mode), 32'h1);
    repeat (19) tick();
    cordic_result = 32'h0000_8000;
    cordic_done = 1'b1;
    tick();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("t1_rsp_data", rsp_data, 32'h0000_8000);
    chk("t1_rsp_err", 32'(rsp_err), 32'h0);
    cordic_done = 1'b0;
    tick();
    chk("t1_idle", 32'(busy), 32'h0);

    // Round robin from a fresh pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < N; i++) req_theta[i*DW +: DW] = 32'(i + 1) << 16;
    req_mode = 4'b1010;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'h1 << exp_order[k]);
      tick();
      tick(); tick();
      cordic_result = Q16_ONE + 32'(k);
      cordic_done = 1'b1;
      tick();
      chk("rr_owner", 32'(rsp_valid), 32'h1 << exp_order[k]);
      chk("rr_data", rsp_data, Q16_ONE + 32'(k));
      cordic_done = 1'b0;
      tick();
    end
    req_valid = '0;
    tick();

    // Watchdog timeout (pointer is now 1).
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("to_start", 32'(cordic_start), 32'h1);
    s_cyc = cyc;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (rsp_valid != '0) seen = 1;
    end
    chk("to_seen", 32'(seen), 32'h1);
    chk("to_latency", 32'(cyc - s_cyc), 32'd64);
    chk("to_err", 32'(rsp_err), 32'h1);
    chk("to_data", rsp_data, 32'h0);
    tick();
    // A late done pulse is ignored.
    cordic_result = 32'hDEAD_BEEF;
    cordic_done = 1'b1;
    tick();
    cordic_done = 1'b0;
    n_rsp = 0;
    repeat (5) begin
      tick();
      if (rsp_valid != '0 || busy) n_rsp++;
    end
    chk("to_late_done", 32'(n_rsp), 32'h0);

    // Level done held for 5 cycles: requester 2, then requester 3 queued.
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick(); tick();
    cordic_result = 32'h0000_DDB4;
    cordic_done = 1'b1;
    n_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid != '0) n_rsp++;
      if (i == 1) req_valid = 4'b1000;
      if (i == 2) req_valid = '0;
    end
    cordic_done = 1'b0;
    chk("lvl_one_rsp", 32'(n_rsp), 32'h1);
    repeat (3) tick();
    chk("lvl_wait_valid", 32'(rsp_valid), 32'h0);
    chk("lvl_wait_busy", 32'(busy), 32'h1);
    cordic_result = 32'h0000_4000;
    cordic_done = 1'b1;
    tick();
    chk("lvl_second", 32'(rsp_valid), 32'h8);
    cordic_done = 1'b0;
    tick();

    // Response backpressure (pointer is now 0).
    rsp_ready = '0;
    req_valid = 4'b0011;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    tick(); tick();
    cordic_result = Q16_ONE;
    cordic_done = 1'b1;
    tick();
    cordic_done = 1'b0;
    chk("bp_valid0", 32'(rsp_valid), 32'h1);
    rsp_ready = 4'b1110;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_data", rsp_data, Q16_ONE);
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 4'b0001;
    tick();
    chk("bp_released", 32'(busy), 32'h0);
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    rsp_ready = '1;
    tick();
    req_valid = '0;
    tick(); tick();

    // Reset while BUSY.
    chk("rst_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_theta", cordic_theta, 32'h0);
    chk("rst_mode", 32'(cordic_mode), 32'h0);
    chk("rst_start", 32'(cordic_start), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    req_theta[2*DW +: DW] = 32'h005A_0000;
    req_valid = 4'b0100;
    #1;
    chk("rst_grant2", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick(); tick();
    cordic_result = 32'h0000_1234;
    cordic_done = 1'b1;
    tick();
    chk("rst_rsp", 32'(rsp_valid), 32'h4);
    chk("rst_rsp_data", rsp_data, 32'h0000_1234);
    cordic_done = 1'b0;
    repeat (3) tick();

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Round-robin scheduler that shares one cordic_top engine between N_REQ requesters. Each requester uses a valid/ready request channel carrying mode and theta_deg (Q16 degrees). The arbiter issues a one-cycle start to the engine and waits for completion or a watchdog timeout. It returns the 32-bit result, with an error flag, on a per-requester valid/ready response channel. It sits between the SoC bus-side clients and cordic_top.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 32, theta/result width (Q16 signed)
TIMEOUT, 64, maximum BUSY cycles before abort (>=2)
ID_W, $clog2(N_REQ), requester index width (derived localparam)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  request pending, per requester
req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
req_mode  in  N_REQ  mode bit per requester (0=cos, 1=sin)
req_theta  in  N_REQ*DATA_W  packed angles, requester i at [i*DATA_W +: DATA_W]
rsp_valid  out  N_REQ  response valid, one-hot to the owning requester
rsp_ready  in  N_REQ  response consumed, per requester
rsp_data  out  DATA_W  result (shared bus)
rsp_err  out  1  1 = timeout; rsp_data is 0
cordic_start  out  1  one-cycle start pulse to the engine
cordic_mode  out  1  latched mode, stable from ISSUE until return to IDLE
cordic_theta  out  DATA_W  latched angle, stable from ISSUE until return to IDLE
cordic_result  in  DATA_W  engine result
cordic_done  in  1  engine done; may be a level or a pulse, rising edge is used
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, rr_ptr=0, all outputs 0, latched id/mode/theta/result=0, done_d=0, timeout counter=0.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE
  - grant = first i with req_valid[i], searching from rr_ptr upward modulo N_REQ.
  - req_ready[grant]=1 combinationally that cycle; no other requester sees ready.
  - On handshake: latch id, mode and theta; rr_ptr <= (grant+1) mod N_REQ; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE
  - cordic_start=1 for exactly this cycle.
  - Clear the counter; go to BUSY.
- BUSY
  - done_edge = cordic_done & ~done_d, where done_d is registered every cycle in all states.
  - On done_edge: latch cordic_result, err=0, go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 with no edge: err=1, data=0, go to RESP.
  - If done_edge and timeout coincide, done wins (err=0).
- RESP
  - rsp_valid[id]=1; rsp_data and rsp_err are held stable.
  - When rsp_ready[id]=1: go to IDLE.
  - rsp_ready on other bits is ignored.
- Latency: accept at cycle t, start at t+1, and rsp_valid one cycle after the done edge is sampled. A new request can be accepted at the earliest one cycle after the response handshake.
- Fairness: after serving requester i, requester i+1 has highest priority. A continuously asserting requester cannot starve the others.
- Done edges in IDLE, ISSUE or RESP are ignored. This includes a late done after a timeout; done_d still tracks it so no false edge follows.
- Requester-side changes to req_theta/req_mode after acceptance have no effect.
- Reset mid-operation returns to IDLE immediately with all outputs deasserted. No response is produced for the in-flight request.
- rsp_data/rsp_err are 0 whenever rsp_valid is all-zero.

Decomposition:
- Shared package cordic_pkg holds:
  - state encoding localparams IDLE/ISSUE/BUSY/RESP (2 bits);
  - Q16 constant Q16_ONE=32'h0001_0000;
  - default TIMEOUT.
- One natural sub-module: rr_arbiter (combinational priority search from rr_ptr). Inputs are req and ptr; outputs are a one-hot grant and the grant index.
- FSM, latches, timeout counter and done-edge detector stay in cordic_arbiter.

Test Plan:
- Single request: req_valid=4'b0001, mode=1, theta=32'h001E_0000 (30°), engine stub done after 20 cycles with result 32'h0000_8000.
  - Expect start exactly one cycle after accept, then rsp_valid=4'b0001, rsp_data=32'h0000_8000, err=0.
- Round-robin: all four req_valid held high.
  - Expect grants in order 0,1,2,3,0.
  - Each rsp_valid goes only to its owner; no back-to-back start without an intervening response handshake.
- Timeout: TIMEOUT=64, stub never asserts done.
  - Expect rsp_err=1 and rsp_data=0 exactly 64 cycles after start.
  - A late done pulse afterwards is ignored and no second response is produced.
- Level done: stub holds cordic_done high for 5 cycles.
  - Expect exactly one response.
  - The next transaction waits for a fresh rising edge.
- Response backpressure: rsp_ready held low for 10 cycles.
  - Expect rsp_valid, rsp_data and rsp_err stable; no new grant.
  - Handshake on cycle 11 returns the FSM to IDLE.
- Reset mid-BUSY: drop rst_n for 1 cycle.
  - Expect all outputs 0 immediately, rr_ptr=0.
  - The next request from requester 2 with req_valid=4'b0100 is granted normally.
